// File: rtl/sort_stat.sv
// Burst statistics on an ascending-sorted stream.
// Reports sum, median of beats 3/4, range and a malformed-burst flag.
module sort_stat #(
   parameter int BEATS = 8,
   parameter int DW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in,
   input  logic          in_valid,
   output logic [DW+2:0] sum,
   output logic [DW-1:0] med,
   output logic [DW-1:0] rng,
   output logic          err,
   output logic          out_valid
);

   localparam int CW = $clog2(BEATS + 2);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] REPORT  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          ord_err;
   logic [DW+2:0] acc;
   logic [DW-1:0] v0;
   logic [DW-1:0] b3;
   logic [DW-1:0] b4;
   logic [DW-1:0] prev;
   logic [DW:0]   mid_sum;
   logic          bad;

   assign mid_sum = {1'b0, b3} + {1'b0, b4};
   assign bad     = (cnt != CW'(BEATS)) | ord_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ord_err   <= 1'b0;
         acc       <= '0;
         v0        <= '0;
         b3        <= '0;
         b4        <= '0;
         prev      <= '0;
         sum       <= '0;
         med       <= '0;
         rng       <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         sum       <= '0;
         med       <= '0;
         rng       <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         unique case (state)
            IDLE, REPORT: begin
               // A beat here is always beat 0 of a fresh burst
               if (in_valid) begin
                  state   <= COLLECT;
                  cnt     <= CW'(1);
                  ord_err <= 1'b0;
                  acc     <= {3'b000, in};
                  v0      <= in;
                  b3      <= '0;
                  b4      <= '0;
                  prev    <= in;
               end else begin
                  state <= IDLE;
               end
            end
            COLLECT: begin
               if (in_valid) begin
                  if (cnt != CW'(BEATS + 1))
                     cnt <= cnt + CW'(1);
                  acc  <= acc + {3'b000, in};
                  prev <= in;
                  if (in < prev)
                     ord_err <= 1'b1;
                  if (cnt == CW'(3))
                     b3 <= in;
                  if (cnt == CW'(4))
                     b4 <= in;
               end else begin
                  state     <= REPORT;
                  out_valid <= 1'b1;
                  err       <= bad;
                  if (!bad) begin
                     sum <= acc;
                     med <= mid_sum[DW:1];
                     rng <= prev - v0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sort_stat.sv
// Directed bench for sort_stat.
// Inputs change #1 after posedge; outputs are checked at that point.
module tb_sort_stat;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] in;
   logic       in_valid;
   logic [8:0] sum;
   logic [5:0] med;
   logic [5:0] rng;
   logic       err;
   logic       out_valid;

   int errors = 0;
   int checks = 0;
   int q[$];

   sort_stat #(.BEATS(8), .DW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in),
      .in_valid  (in_valid),
      .sum       (sum),
      .med       (med),
      .rng       (rng),
      .err       (err),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int v);
      in_valid = 1'b1;
      in       = 6'(v);
      step();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in       = 'x;
      step();
   endtask

   task automatic send_q(input string tag);
      foreach (q[i]) begin
         beat(q[i]);
         chk({tag, ".ov_busy"}, int'(out_valid), 0);
      end
   endtask

   task automatic exp_rep(input string tag, input int s, input int m,
                          input int r, input int e);
      chk({tag, ".ov"}, int'(out_valid), 1);
      chk({tag, ".sum"}, int'(sum), s);
      chk({tag, ".med"}, int'(med), m);
      chk({tag, ".rng"}, int'(rng), r);
      chk({tag, ".err"}, int'(err), e);
   endtask

   task automatic exp_zero(input string tag);
      chk({tag, ".ov0"}, int'(out_valid), 0);
      chk({tag, ".sum0"}, int'(sum), 0);
      chk({tag, ".med0"}, int'(med), 0);
      chk({tag, ".rng0"}, int'(rng), 0);
      chk({tag, ".err0"}, int'(err), 0);
   endtask

   initial begin
      // in_valid held high during reset must be ignored
      rst      = 1'b1;
      in_valid = 1'b1;
      in       = 6'd9;
      step();
      step();
      exp_zero("reset");
      rst = 1'b0;
      idle();
      exp_zero("post_reset");
      idle();
      exp_zero("post_reset2");

      q = {2, 5, 9, 9, 14, 20, 33, 62};
      send_q("nom");
      idle();
      exp_rep("nom", 154, 11, 60, 0);
      idle();
      exp_zero("nom_after");

      q = {1, 2, 3, 4, 5, 6, 7};
      send_q("short");
      idle();
      exp_rep("short", 0, 0, 0, 1);
      idle();
      exp_zero("short_after");

      q = {3, 3, 3, 3, 3, 3, 3, 3, 3};
      send_q("long");
      idle();
      exp_rep("long", 0, 0, 0, 1);
      idle();
      q = {10, 10, 10, 10, 10, 10, 10, 10};
      send_q("tens");
      idle();
      exp_rep("tens", 80, 10, 0, 0);
      idle();

      q = {1, 2, 3, 8, 4, 5, 6, 7};
      send_q("order");
      idle();
      exp_rep("order", 0, 0, 0, 1);
      idle();

      q = {0, 1, 2, 3, 4, 5, 6, 7};
      send_q("b2b_a");
      idle();
      exp_rep("b2b_a", 28, 3, 7, 0);
      q = {10, 20, 30, 40, 50, 60, 62, 63};
      send_q("b2b_b");
      idle();
      exp_rep("b2b_b", 335, 45, 53, 0);
      idle();
      exp_zero("b2b_after");

      q = {4, 6, 8, 10, 12};
      send_q("rst_mid");
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      exp_zero("rst_mid");
      rst = 1'b0;
      idle();
      exp_zero("rst_mid_i1");
      idle();
      exp_zero("rst_mid_i2");
      q = {5, 5, 6, 7, 8, 9, 9, 60};
      send_q("rst_next");
      idle();
      exp_rep("rst_next", 109, 7, 55, 0);
      idle();

      q = {63, 63, 63, 63, 63, 63, 63, 63};
      send_q("max");
      idle();
      exp_rep("max", 504, 63, 0, 0);
      rst = 1'b1;
      step();
      exp_zero("rst_report");
      rst = 1'b0;
      idle();
      exp_zero("rst_report_i");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
